uart_tx_frame: RTL and testbench

Parametrised UART transmit engine that generalises the CoreUARTapb transmitter: a configurable-depth internal TX FIFO and runtime-selectable 5..DATA_W data bits. It also supports none/even/odd parity, 1 or 2 stop bits, break generation, a transmit-empty indication and FIFO overflow detection. It sits between the APB register file, which pushes words and drives configuration, and the `tx` pad. Bit timing comes from the existing baud generator's `xmit_pulse`.

---
 rtl/uart_tx_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit engine: TX FIFO feeding a framing FSM.
// The frame is start, 5..DATA_W data bits LSB first, optional parity, then 1 or 2 stop bits; break is also supported.
module uart_tx_frame #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              xmit_pulse,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        data_len,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              stop2,
  input  logic              send_break,
  output logic              tx,
  output logic              txrdy,
  output logic              tx_empty,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]       MIN_LEN  = 4'd5;
  localparam logic [3:0]       MAX_LEN  = 4'(DATA_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              push_c;
  logic              pop_c;

  // Framing state
  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic [3:0]        len_q, len_d;
  logic              par_en_q, par_en_d;
  logic              odd_q, odd_d;
  logic              stop2_q, stop2_d;
  logic              boundary_c;
  logic [3:0]        eff_len_c;

  // Registered status outputs
  logic              txrdy_q, txrdy_d;
  logic              tx_empty_q, tx_empty_d;
  logic              overflow_q, overflow_d;

  assign fifo_full_c  = (count_q == FULL_CNT);
  assign fifo_empty_c = (count_q == '0);
  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
  assign push_c       = wr_en && (!fifo_full_c || pop_c);

  assign eff_len_c = (data_len < MIN_LEN) ? MIN_LEN :
                     (data_len > MAX_LEN) ? MAX_LEN : data_len;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Next-state and bit-level output; everything advances only on xmit_pulse.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    odd_d      = odd_q;
    stop2_d    = stop2_q;
    pop_c      = 1'b0;
    boundary_c = 1'b0;

    if (xmit_pulse) begin
      unique case (state_q)
        S_IDLE: begin
          boundary_c = 1'b1;
        end
        S_START: begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          par_d     = par_q ^ shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_cnt_d = '0;
        end
        S_DATA: begin
          if (bit_cnt_q < 4'(len_q - 4'd1)) begin
            tx_d      = shift_q[0];
            par_d     = par_q ^ shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_q ^ odd_q;
          end else begin
            state_d = S_STOP1;
            tx_d    = 1'b1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP1;
          tx_d    = 1'b1;
        end
        S_STOP1: begin
          if (stop2_q) begin
            state_d = S_STOP2;
            tx_d    = 1'b1;
          end else begin
            boundary_c = 1'b1;
          end
        end
        S_STOP2: begin
          boundary_c = 1'b1;
        end
        S_BREAK: begin
          if (send_break) begin
            tx_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase

      // Frame boundary: break has priority, then the next queued word, else idle.
      if (boundary_c) begin
        if (send_break) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
        end else if (!fifo_empty_c) begin
          pop_c    = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          len_d    = eff_len_c;
          par_en_d = parity_en;
          odd_d    = odd_n_even;
          stop2_d  = stop2;
          par_d    = 1'b0;
          state_d  = S_START;
          tx_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    txrdy_d    = (count_d != FULL_CNT);
    tx_empty_d = (count_d == '0) && (state_d == S_IDLE);
    overflow_d = wr_en && fifo_full_c && !pop_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      len_q      <= MAX_LEN;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      stop2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      txrdy_q    <= 1'b1;
      tx_empty_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      odd_q      <= odd_d;
      stop2_q    <= stop2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      txrdy_q    <= txrdy_d;
      tx_empty_q <= tx_empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign txrdy      = txrdy_q;
  assign tx_empty   = tx_empty_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: expected frames are queued at push time; a line monitor reassembles tx and compares.
module tb_uart_tx_frame;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = 5;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              xmit_pulse;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [3:0]        data_len = 4'd8;
  logic              parity_en = 1'b0;
  logic              odd_n_even = 1'b0;
  logic              stop2 = 1'b0;
  logic              send_break = 1'b0;
  logic              tx;
  logic              txrdy;
  logic              tx_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;

  int     checks = 0;
  int     failures = 0;
  int     pulse_div = 16;
  int     pg_cnt = 0;
  bit     pg_en = 1'b1;
  logic   pg_pulse = 1'b0;
  logic   man_pulse = 1'b0;

  frame_t sb[$];
  frame_t cur;
  logic [15:0] got;
  int     idx = 0;
  bit     in_frame = 1'b0;
  bit     allow_break = 1'b0;
  int     idle_run = 0;
  int     frames_done = 0;
  int     gap_log[$];
  int     start_cnt[$];

  assign xmit_pulse = pg_pulse | man_pulse;

  uart_tx_frame #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .xmit_pulse(xmit_pulse),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data_len  (data_len),
    .parity_en (parity_en),
    .odd_n_even(odd_n_even),
    .stop2     (stop2),
    .send_break(send_break),
    .tx        (tx),
    .txrdy     (txrdy),
    .tx_empty  (tx_empty),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;

  // Baud strobe: one clk high every pulse_div clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (pg_en && pg_cnt >= pulse_div - 1) begin
        pg_pulse = 1'b1;
        pg_cnt   = 0;
      end else begin
        pg_pulse = 1'b0;
        pg_cnt   = pg_en ? pg_cnt + 1 : 0;
      end
    end
  end

  // Reference frame built straight from the UART frame definition.
  function automatic frame_t model_frame(input logic [DATA_W-1:0] d, input int dl,
                                         input bit pe, input bit odd, input bit s2);
    frame_t f;
    int     len;
    bit     p;
    len    = (dl < 5) ? 5 : ((dl > int'(DATA_W)) ? int'(DATA_W) : dl);
    f.bits = '0;
    f.n    = 1;
    p      = 1'b0;
    for (int i = 0; i < len; i++) begin
      f.bits[f.n] = d[i];
      p           = p ^ d[i];
      f.n++;
    end
    if (pe) begin
      f.bits[f.n] = p ^ odd;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(model_frame(d, int'(data_len), parity_en, odd_n_even, stop2));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pulse();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!xmit_pulse && k < 2000);
    if (!xmit_pulse) fail_now("pulse_wait");
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (frames_done < target) fail_now("frame_wait");
  endtask

  task automatic set_cfg(input int dl, input bit pe, input bit odd, input bit s2);
    @(negedge clk);
    data_len   = 4'(dl);
    parity_en  = pe;
    odd_n_even = odd;
    stop2      = s2;
  endtask

  // Line monitor: samples tx just after every bit strobe and rebuilds frames.
  initial begin
    forever begin
      @(posedge clk);
      if (xmit_pulse && reset_n) begin
        #1;
        if (!in_frame) begin
          if (tx === 1'b0) begin
            if (sb.size() > 0) begin
              cur      = sb.pop_front();
              got      = '0;
              idx      = 1;
              in_frame = 1'b1;
              start_cnt.push_back(int'(fifo_count));
              gap_log.push_back(idle_run);
              idle_run = 0;
            end else if (!allow_break) begin
              fail_now("unexpected_start");
            end
          end else begin
            idle_run++;
          end
        end else begin
          got[idx] = tx;
          idx++;
          if (idx == cur.n) begin
            check("frame_bits", 32'(got), 32'(cur.bits));
            in_frame = 1'b0;
            frames_done++;
          end
        end
      end else if (!reset_n) begin
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] r;
    int n;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_txrdy", 32'(txrdy), 32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 8N1 0xA5
    set_cfg(8, 0, 0, 0);
    push(8'hA5, 1);
    check("push_tx_empty_low", 32'(tx_empty), 32'd0);
    check("push_count_one", 32'(fifo_count), 32'd1);
    wait_frames(frames_done + 1, 400);
    wait_pulse();
    check("tx_empty_after_frame", 32'(tx_empty), 32'd1);
    check("idle_tx_high", 32'(tx), 32'd1);

    // 7E2 0x41, then 8O1 0xA5
    set_cfg(7, 1, 0, 1);
    push(8'h41, 1);
    wait_frames(frames_done + 1, 400);
    set_cfg(8, 1, 1, 0);
    push(8'hA5, 1);
    wait_frames(frames_done + 1, 400);

    // Three words back-to-back, 8N1
    set_cfg(8, 0, 0, 0);
    wait_pulse();
    gap_log.delete();
    start_cnt.delete();
    push(8'h11, 1);
    push(8'hE7, 1);
    push(8'h5A, 1);
    wait_frames(frames_done + 3, 1000);
    if (start_cnt.size() >= 3 && gap_log.size() >= 3) begin
      check("b2b_count0", 32'(start_cnt[0]), 32'd2);
      check("b2b_count1", 32'(start_cnt[1]), 32'd1);
      check("b2b_count2", 32'(start_cnt[2]), 32'd0);
      check("b2b_gap1", 32'(gap_log[1]), 32'd0);
      check("b2b_gap2", 32'(gap_log[2]), 32'd0);
    end else begin
      fail_now("b2b_frames_seen");
    end

    // Fill FIFO with no strobes, overflow, then push+pop while full
    wait_pulse();
    @(negedge clk);
    pg_en = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      r = DATA_W'($urandom);
      push(r, 1);
      if (i == int'(FIFO_DEPTH) - 2) begin
        check("almost_full_txrdy", 32'(txrdy), 32'd1);
        check("almost_full_count", 32'(fifo_count), 32'(FIFO_DEPTH - 1));
      end
    end
    check("full_txrdy", 32'(txrdy), 32'd0);
    check("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    check("full_no_overflow", 32'(overflow), 32'd0);
    push(8'hFF, 0);
    check("overflow_pulse", 32'(overflow), 32'd1);
    check("overflow_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    @(negedge clk);
    check("overflow_one_cycle", 32'(overflow), 32'd0);
    r = DATA_W'($urandom);
    wr_en     = 1'b1;
    wr_data   = r;
    man_pulse = 1'b1;
    sb.push_back(model_frame(r, int'(data_len), parity_en, odd_n_even, stop2));
    @(negedge clk);
    wr_en     = 1'b0;
    man_pulse = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    check("pushpop_no_overflow", 32'(overflow), 32'd0);
    check("pushpop_txrdy", 32'(txrdy), 32'd0);
    pg_en = 1'b1;
    wait_frames(frames_done + int'(FIFO_DEPTH) + 1, 4000);

    // Break requested mid-frame
    allow_break = 1'b1;
    push(8'h3C, 1);
    repeat (3) wait_pulse();
    @(negedge clk);
    send_break = 1'b1;
    wait_frames(frames_done + 1, 400);
    wait_pulse();
    check("break_entered", 32'(tx), 32'd0);
    check("break_not_empty", 32'(tx_empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_pulse();
      check("break_hold", 32'(tx), 32'd0);
    end
    @(negedge clk);
    send_break = 1'b0;
    wait_pulse();
    check("break_exit", 32'(tx), 32'd1);
    allow_break = 1'b0;

    // Asynchronous reset in the middle of a frame
    push(8'h96, 1);
    push(8'h69, 1);
    push(8'hF0, 1);
    repeat (4) wait_pulse();
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_txrdy", 32'(txrdy), 32'd1);
    check("midrst_tx_empty", 32'(tx_empty), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push(8'hC3, 1);
    wait_frames(frames_done + 1, 400);

    // Randomized configurations and data
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      pulse_div = $urandom_range(20, 4);
      set_cfg($urandom_range(15, 0), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n = $urandom_range(3, 1);
      for (int k = 0; k < n; k++) begin
        r = DATA_W'($urandom);
        push(r, 1);
      end
      wait_frames(frames_done + n, n * 14 * 21 + 200);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
